// File: rtl/wb_stage_if.sv
// Memory-stage to write-back bundle: captured candidate values in, register-file
// write port and forwarding taps out.
interface wb_stage_if;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wdsel;
    logic [31:0] mem_alu;
    logic [31:0] mem_pc4;
    logic [31:0] mem_imm;
    logic [31:0] mem_rdata;
    logic [2:0]  mem_dmtype;
    logic [1:0]  mem_addr_lo;

    logic        RFWr;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic        wb_valid;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;

    modport master (
        output stall, flush, mem_valid, mem_regwrite, mem_rd, mem_wdsel,
               mem_alu, mem_pc4, mem_imm, mem_rdata, mem_dmtype, mem_addr_lo,
        input  RFWr, A3, WD, wb_valid, fwd_en, fwd_rd, fwd_data, instret
    );

    modport slave (
        input  stall, flush, mem_valid, mem_regwrite, mem_rd, mem_wdsel,
               mem_alu, mem_pc4, mem_imm, mem_rdata, mem_dmtype, mem_addr_lo,
        output RFWr, A3, WD, wb_valid, fwd_en, fwd_rd, fwd_data, instret
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load alignment, write-back mux,
// register-file write port and a 64-bit retired-instruction counter.
module wb_stage #(
    parameter logic [31:0] RESET_PC4 = 32'h0000_0000
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave bus
);

    logic        valid_q;
    logic        regwrite_q;
    logic [4:0]  rd_q;
    logic [1:0]  wdsel_q;
    logic [31:0] alu_q;
    logic [31:0] pc4_q;
    logic [31:0] imm_q;
    logic [31:0] rdata_q;
    logic [2:0]  dmtype_q;
    logic [1:0]  addr_lo_q;
    logic [63:0] instret_q;

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] sel_val;
    logic        rfwr;

    // Flush only needs to kill valid/regwrite; the payload is don't-care.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            wdsel_q    <= 2'd0;
            alu_q      <= 32'd0;
            pc4_q      <= RESET_PC4;
            imm_q      <= 32'd0;
            rdata_q    <= 32'd0;
            dmtype_q   <= 3'd0;
            addr_lo_q  <= 2'd0;
        end else if (bus.flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q    <= bus.mem_valid;
            regwrite_q <= bus.mem_regwrite;
            rd_q       <= bus.mem_rd;
            wdsel_q    <= bus.mem_wdsel;
            alu_q      <= bus.mem_alu;
            pc4_q      <= bus.mem_pc4;
            imm_q      <= bus.mem_imm;
            rdata_q    <= bus.mem_rdata;
            dmtype_q   <= bus.mem_dmtype;
            addr_lo_q  <= bus.mem_addr_lo;
        end
    end

    // Count on the edge that lets the slot go, so a held instruction retires once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= 64'd0;
        end else if (valid_q && !bus.stall) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    always_comb begin
        byte_val = 8'd0;
        unique case (addr_lo_q)
            2'd0: byte_val = rdata_q[7:0];
            2'd1: byte_val = rdata_q[15:8];
            2'd2: byte_val = rdata_q[23:16];
            2'd3: byte_val = rdata_q[31:24];
        endcase
        half_val = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

        load_val = rdata_q;
        case (dmtype_q)
            3'b000:  load_val = {{24{byte_val[7]}}, byte_val};
            3'b001:  load_val = {{16{half_val[15]}}, half_val};
            3'b100:  load_val = {24'd0, byte_val};
            3'b101:  load_val = {16'd0, half_val};
            default: load_val = rdata_q;
        endcase
    end

    always_comb begin
        sel_val = 32'd0;
        unique case (wdsel_q)
            2'b00: sel_val = alu_q;
            2'b01: sel_val = load_val;
            2'b10: sel_val = pc4_q;
            2'b11: sel_val = imm_q;
        endcase
    end

    assign rfwr = valid_q & regwrite_q & (rd_q != 5'd0);

    assign bus.RFWr     = rfwr;
    assign bus.A3       = valid_q ? rd_q : 5'd0;
    assign bus.WD       = rfwr ? sel_val : 32'd0;
    assign bus.wb_valid = valid_q;
    assign bus.fwd_en   = rfwr;
    assign bus.fwd_rd   = valid_q ? rd_q : 5'd0;
    assign bus.fwd_data = rfwr ? sel_val : 32'd0;
    assign bus.instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage with directed corner cases, checked against a
// behavioural model of the write-back slot and retire count.
module tb_wb_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    wb_stage_if bus ();

    wb_stage #(
        .RESET_PC4(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction currently sitting in write-back.
    bit              m_valid;
    bit              m_regwrite;
    int unsigned     m_rd;
    int unsigned     m_wdsel;
    int unsigned     m_alu;
    int unsigned     m_pc4;
    int unsigned     m_imm;
    int unsigned     m_rdata;
    int unsigned     m_dmtype;
    int unsigned     m_lo;
    longint unsigned m_instret;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned load_value();
        int unsigned b;
        int unsigned h;
        b = (m_rdata >> (8 * m_lo)) & 32'hFF;
        h = (m_rdata >> (16 * (m_lo / 2))) & 32'hFFFF;
        case (m_dmtype)
            0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4: return b;
            5: return h;
            default: return m_rdata;
        endcase
    endfunction

    function automatic bit exp_rfwr();
        return m_valid && m_regwrite && (m_rd != 0);
    endfunction

    function automatic int unsigned exp_wd();
        if (!exp_rfwr()) return 0;
        case (m_wdsel)
            0: return m_alu;
            1: return load_value();
            2: return m_pc4;
            default: return m_imm;
        endcase
    endfunction

    function automatic int unsigned exp_a3();
        return m_valid ? m_rd : 0;
    endfunction

    task automatic model_reset();
        m_valid    = 0;
        m_regwrite = 0;
        m_rd       = 0;
        m_wdsel    = 0;
        m_alu      = 0;
        m_pc4      = 0;
        m_imm      = 0;
        m_rdata    = 0;
        m_dmtype   = 0;
        m_lo       = 0;
        m_instret  = 0;
    endtask

    // Applies the rising-edge rules to the inputs present at that edge.
    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_valid && !bus.stall) m_instret++;
        if (bus.flush) begin
            m_valid    = 0;
            m_regwrite = 0;
        end else if (!bus.stall) begin
            m_valid    = bus.mem_valid;
            m_regwrite = bus.mem_regwrite;
            m_rd       = bus.mem_rd;
            m_wdsel    = bus.mem_wdsel;
            m_alu      = bus.mem_alu;
            m_pc4      = bus.mem_pc4;
            m_imm      = bus.mem_imm;
            m_rdata    = bus.mem_rdata;
            m_dmtype   = bus.mem_dmtype;
            m_lo       = bus.mem_addr_lo;
        end
    endtask

    task automatic check_model(input string ctx);
        check_eq({ctx, ".RFWr"}, bus.RFWr, exp_rfwr());
        check_eq({ctx, ".A3"}, bus.A3, exp_a3());
        check_eq({ctx, ".WD"}, bus.WD, exp_wd());
        check_eq({ctx, ".wb_valid"}, bus.wb_valid, m_valid);
        check_eq({ctx, ".fwd_en"}, bus.fwd_en, exp_rfwr());
        check_eq({ctx, ".fwd_rd"}, bus.fwd_rd, exp_a3());
        check_eq({ctx, ".fwd_data"}, bus.fwd_data, exp_wd());
        check_eq({ctx, ".instret"}, bus.instret, m_instret);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_model(ctx);
    endtask

    task automatic drive(input bit valid, input bit regwrite, input logic [4:0] rd,
                         input logic [1:0] wdsel, input logic [31:0] val,
                         input logic [2:0] dmtype, input logic [1:0] lo,
                         input bit stall, input bit flush);
        bus.mem_valid    = valid;
        bus.mem_regwrite = regwrite;
        bus.mem_rd       = rd;
        bus.mem_wdsel    = wdsel;
        bus.mem_alu      = val;
        bus.mem_pc4      = val;
        bus.mem_imm      = val;
        bus.mem_rdata    = val;
        bus.mem_dmtype   = dmtype;
        bus.mem_addr_lo  = lo;
        bus.stall        = stall;
        bus.flush        = flush;
    endtask

    task automatic drive_random(input bit stall, input bit flush);
        bus.mem_valid    = 1'($urandom);
        bus.mem_regwrite = 1'($urandom);
        bus.mem_rd       = 5'($urandom);
        bus.mem_wdsel    = 2'($urandom);
        bus.mem_alu      = $urandom;
        bus.mem_pc4      = $urandom;
        bus.mem_imm      = $urandom;
        bus.mem_rdata    = $urandom;
        bus.mem_dmtype   = 3'($urandom);
        bus.mem_addr_lo  = 2'($urandom);
        bus.stall        = stall;
        bus.flush        = flush;
    endtask

    task automatic drive_idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    logic [31:0]     ld_exp [5];
    logic [2:0]      ld_type [5];
    logic [1:0]      ld_lo [5];
    longint unsigned inst_snap;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst = 1'b0;

        // Reset held with random inputs: every output quiet.
        for (int i = 0; i < 3; i++) begin
            drive_random(1'($urandom), 1'($urandom));
            step("reset");
            check_eq("reset.RFWr", bus.RFWr, 0);
            check_eq("reset.WD", bus.WD, 0);
            check_eq("reset.instret", bus.instret, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        step("idle0");
        step("idle1");
        check_eq("idle.instret", bus.instret, 0);
        check_eq("idle.A3", bus.A3, 0);

        // ALU then LUI write-back.
        drive(1, 1, 5, 2'b00, 32'h1234_5678, 0, 0, 0, 0);
        step("alu");
        check_eq("alu.A3", bus.A3, 5);
        check_eq("alu.WD", bus.WD, 32'h1234_5678);
        drive(1, 1, 6, 2'b11, 32'hABCD_E000, 0, 0, 0, 0);
        step("lui");
        check_eq("lui.A3", bus.A3, 6);
        check_eq("lui.WD", bus.WD, 32'hABCD_E000);
        drive_idle();
        step("post_lui");
        check_eq("post_lui.instret", bus.instret, 2);

        // Load alignment table on one memory word.
        ld_type[0] = 3'b000; ld_lo[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
        ld_type[1] = 3'b100; ld_lo[1] = 2'd1; ld_exp[1] = 32'h0000_007F;
        ld_type[2] = 3'b001; ld_lo[2] = 2'd2; ld_exp[2] = 32'hFFFF_80FF;
        ld_type[3] = 3'b101; ld_lo[3] = 2'd0; ld_exp[3] = 32'h0000_7F01;
        ld_type[4] = 3'b010; ld_lo[4] = 2'd0; ld_exp[4] = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 9, 2'b01, 32'h80FF_7F01, ld_type[i], ld_lo[i], 0, 0);
            step("load");
            check_eq("load.WD", bus.WD, ld_exp[i]);
        end

        // x0 destination: retires but never writes.
        drive(1, 1, 0, 2'b10, 32'h0000_0044, 0, 0, 0, 0);
        step("x0");
        check_eq("x0.RFWr", bus.RFWr, 0);
        check_eq("x0.WD", bus.WD, 0);
        check_eq("x0.wb_valid", bus.wb_valid, 1);
        inst_snap = bus.instret;
        drive_idle();
        step("post_x0");
        check_eq("x0.instret", bus.instret, inst_snap + 1);

        // Stall a valid writer for three cycles; new inputs must be ignored.
        drive(1, 1, 7, 2'b00, 32'hCAFE_0007, 0, 0, 0, 0);
        step("stall0");
        check_eq("stall.A3", bus.A3, 7);
        inst_snap = bus.instret;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 12, 2'b00, 32'h1111_0000, 0, 0, 1, 0);
            step("stall");
            check_eq("stall.RFWr", bus.RFWr, 1);
            check_eq("stall.A3", bus.A3, 7);
            check_eq("stall.instret", bus.instret, inst_snap);
        end
        drive_idle();
        step("release");
        check_eq("release.instret", bus.instret, inst_snap + 1);

        // Stall and flush together: flush wins.
        drive(1, 1, 8, 2'b00, 32'h0000_0088, 0, 0, 0, 0);
        step("pre_flush");
        drive(1, 1, 10, 2'b00, 32'h0000_00AA, 0, 0, 1, 1);
        step("flush");
        check_eq("flush.RFWr", bus.RFWr, 0);
        check_eq("flush.wb_valid", bus.wb_valid, 0);

        // Asynchronous reset between edges while a write is in flight.
        drive(1, 1, 3, 2'b00, 32'h0BAD_F00D, 0, 0, 0, 0);
        step("pre_arst");
        check_eq("pre_arst.RFWr", bus.RFWr, 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("arst.RFWr", bus.RFWr, 0);
        check_eq("arst.WD", bus.WD, 0);
        check_eq("arst.instret", bus.instret, 0);
        check_model("arst");
        @(negedge clk);
        rst = 1'b1;

        // Random traffic with occasional stall and flush.
        for (int i = 0; i < 1500; i++) begin
            drive_random($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            step("rand");
        end
        drive_idle();
        step("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
